// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the five-stage pipeline controller:
// stall patterns, eret code, controller FSM encoding and request priority.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  // The deepest requesting stage dominates: it must freeze everything upstream of it.
  function automatic logic [5:0] req_pattern(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, asynchronous reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector from per-stage requests, exception flush and
// redirect, debug halt/drain/resume sequencing and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        dbg_halted,
  output logic [31:0] stall_cnt
);

  localparam int                DCNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  state_e            state_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              dbg_halted_q;

  logic       exc;
  logic [5:0] req;
  logic [5:0] drain_stall;
  logic       drain_step;
  logic       cnt_inc;

  assign exc         = (excepttype_i != EXC_NONE);
  assign req         = req_pattern(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
  assign drain_stall = req | STALL_IF;
  // An IF request does not block draining: only downstream requests keep instructions in flight.
  assign drain_step  = (state_q == ST_DRAIN) && !exc && (drain_stall == STALL_IF);
  assign cnt_inc     = (state_q == ST_RUN) && !exc && (req[0] == STOP);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = '0;
    if (!rst) begin
      stall  = STALL_NONE;
    end else if (exc) begin
      flush  = 1'b1;
      new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      unique case (state_q)
        ST_RUN:    stall = req;
        ST_DRAIN:  stall = drain_stall;
        ST_HALTED: stall = STALL_IF;
        default:   stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      dcnt_q       <= '0;
      dbg_halted_q <= 1'b0;
    end else begin
      // Registered from the current state, so it trails the state transition by one cycle.
      dbg_halted_q <= (state_q == ST_HALTED);
      unique case (state_q)
        ST_RUN: begin
          if (dbg_halt_req) begin
            // A flush empties the pipe by itself, so draining is unnecessary.
            state_q <= exc ? ST_HALTED : ST_DRAIN;
            dcnt_q  <= '0;
          end
        end
        ST_DRAIN: begin
          if (exc) begin
            state_q <= ST_HALTED;
          end else if (drain_step) begin
            if (dcnt_q == DCNT_LAST) begin
              state_q <= ST_HALTED;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (dbg_resume && !exc) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

  assign dbg_halted = dbg_halted_q;

  sat_counter #(
    .WIDTH(32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (cnt_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes expected outputs from a
// behavioural model; a monitor pops and compares each cycle before the rising edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic        dbg_halt_req, dbg_resume;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        dbg_halted;
  logic [31:0] stall_cnt;

  logic        sc_inc, sc_clr;
  logic [2:0]  sc_count;

  int tests = 0;
  int fails = 0;
  bit driver_done = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .dbg_halted(dbg_halted), .stall_cnt(stall_cnt)
  );

  // Narrow instance so saturation is reachable in a short run.
  sat_counter #(.WIDTH(3)) u_sat (
    .clk(clk), .rst_n(rst), .inc(sc_inc), .clr(sc_clr), .count(sc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        halted;
    logic [31:0] cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: mode 0=run, 1=drain, 2=halted; drain counts cycles remaining.
  int              m_mode;
  int              m_left;
  bit              m_halted;
  longint unsigned m_cnt;
  int              cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pat_of(input bit i, input bit d, input bit e, input bit m);
    if (m) return 6'b011111;
    if (e) return 6'b001111;
    if (d) return 6'b000111;
    if (i) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic drive(input bit r, input bit ri, input bit rd, input bit re, input bit rm,
                       input logic [31:0] et, input logic [31:0] epc,
                       input bit halt, input bit resume);
    exp_t e;
    bit   exc;
    bit   downstream;
    logic [5:0] pat;
    @(negedge clk);
    rst = r; stallreq_if = ri; stallreq_id = rd; stallreq_ex = re; stallreq_mem = rm;
    excepttype_i = et; cp0_epc_i = epc; dbg_halt_req = halt; dbg_resume = resume;
    cyc++;
    if (!r) begin
      m_mode = 0; m_left = 0; m_halted = 0; m_cnt = 0;
    end
    exc        = (et != 32'd0);
    pat        = pat_of(ri, rd, re, rm);
    downstream = rd | re | rm;
    e.cyc    = cyc;
    e.halted = m_halted;
    e.cnt    = m_cnt[31:0];
    e.flush  = r && exc;
    e.new_pc = (r && exc) ? ((et == 32'h0000_000e) ? epc : 32'h0000_0020) : 32'd0;
    if (!r || exc)        e.stall = 6'b000000;
    else if (m_mode == 0) e.stall = pat;
    else if (m_mode == 1) e.stall = pat | 6'b000011;
    else                  e.stall = 6'b000011;
    sb.push_back(e);
    if (r) begin
      if (m_mode == 0 && !exc && pat[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_halted = (m_mode == 2);
      case (m_mode)
        0: if (halt) begin
             if (exc) m_mode = 2;
             else begin m_mode = 1; m_left = 4; end
           end
        1: if (exc) m_mode = 2;
           else if (!downstream) begin
             m_left--;
             if (m_left == 0) m_mode = 2;
           end
        default: if (resume && !exc) m_mode = 0;
      endcase
    end
  endtask

  task automatic idle(input bit halt, input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 32'd0, 32'd0, halt, 0);
  endtask

  // Monitor: one expected entry per cycle, compared shortly after the driving edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("stall@%0d", e.cyc),   {26'd0, stall}, {26'd0, e.stall});
        check($sformatf("flush@%0d", e.cyc),   {31'd0, flush}, {31'd0, e.flush});
        check($sformatf("new_pc@%0d", e.cyc),  new_pc, e.new_pc);
        check($sformatf("halted@%0d", e.cyc),  {31'd0, dbg_halted}, {31'd0, e.halted});
        check($sformatf("stall_cnt@%0d", e.cyc), stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit halt_lvl;
    int unsigned et_sel;
    logic [31:0] et;
    rst = 0; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype_i = 0; cp0_epc_i = 0; dbg_halt_req = 0; dbg_resume = 0;
    sc_inc = 0; sc_clr = 0;
    m_mode = 0; m_left = 0; m_halted = 0; m_cnt = 0;

    // Reset held with busy inputs: outputs must stay zero.
    drive(0, 1, 1, 1, 1, 32'h8, 32'h1234, 1, 1);
    drive(0, 0, 0, 0, 1, 32'd0, 32'd0, 0, 0);
    // id + mem together.
    for (int k = 0; k < 3; k++) drive(1, 0, 1, 0, 1, 32'd0, 32'd0, 0, 0);
    // Exception with ex request, then eret.
    drive(1, 0, 0, 1, 0, 32'h0000_0008, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 0, 32'h0000_000e, 32'h8000_1234, 0, 0);
    // Halt with no requests, then resume with halt held (single step).
    idle(1, 7);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1, 1);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
    // Two mem-request cycles inside DRAIN; halt request drops mid-drain.
    drive(1, 0, 0, 0, 1, 32'd0, 32'd0, 1, 0);
    drive(1, 0, 0, 0, 1, 32'd0, 32'd0, 0, 0);
    idle(0, 6);
    // Exception while HALTED keeps the state; then resume.
    drive(1, 0, 0, 0, 0, 32'h0000_0004, 32'd0, 0, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1);
    idle(0, 2);
    // Halt coincident with exception goes straight to HALTED.
    drive(1, 0, 1, 0, 0, 32'h0000_000c, 32'd0, 1, 0);
    idle(0, 2);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1);
    // Reset pulse in the middle of a drain.
    drive(1, 1, 0, 0, 0, 32'd0, 32'd0, 1, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0);
    idle(0, 3);

    // Randomized traffic.
    halt_lvl = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) halt_lvl = ~halt_lvl;
      et_sel = $urandom_range(0, 15);
      et = (et_sel == 0) ? 32'h0000_000e : (et_sel == 1) ? ($urandom() | 32'h1) : 32'd0;
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            et, $urandom(), halt_lvl, ($urandom_range(0, 5) == 0));
    end
    idle(0, 1);
    @(negedge clk);
    @(negedge clk);
    #4;
    check("scoreboard_empty", sb.size(), 32'd0);
    driver_done = 1;

    // Saturation on a 3-bit instance: 10 increments must stop at 7, clear returns to 0.
    @(negedge clk);
    sc_inc = 1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check($sformatf("sat_count_%0d", n), {29'd0, sc_count}, (n > 7) ? 32'd7 : n);
    end
    sc_inc = 0; sc_clr = 1;
    @(negedge clk);
    check("sat_clr", {29'd0, sc_count}, 32'd0);
    sc_clr = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage core. It turns per-stage stall requests into the `stall[5:0]` vector consumed by pc_reg and the stage registers. On an exception or eret reported from MEM it raises `flush` and supplies the redirect PC. It also runs a debug halt/drain/resume sequence and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020, exception handler entry PC.
- DRAIN_CYCLES, 4, stall-free cycles needed to empty ID..WB before halting (≥1).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  fetch not ready (instruction memory wait).
- stallreq_id  in  1  load-use interlock.
- stallreq_ex  in  1  multi-cycle EX operation busy.
- stallreq_mem  in  1  data memory wait.
- excepttype_i  in  32  exception code from MEM; 0 means none; 32'h0000_000e means eret.
- cp0_epc_i  in  32  current EPC from CP0.
- dbg_halt_req  in  1  level request to halt the core.
- dbg_resume  in  1  one-cycle pulse to leave HALTED.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- flush  out  1  clear all stage registers and load new_pc.
- new_pc  out  32  redirect target; valid only while flush=1, otherwise 0.
- dbg_halted  out  1  core is halted with an empty pipeline.
- stall_cnt  out  32  count of request-caused PC stall cycles, saturating.

## Operation
- Request patterns; the highest stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- Exception (excepttype_i≠0):
  - flush=1 and stall=0 in the same cycle, regardless of requests or state.
  - new_pc=cp0_epc_i when excepttype_i==32'h0000_000e, else EXC_VECTOR.
- FSM states are RUN, DRAIN and HALTED, with drain counter dcnt.
- RUN:
  - stall = request pattern.
  - dbg_halt_req=1 with no exception → DRAIN, dcnt=0.
  - dbg_halt_req=1 with an exception in the same cycle → flush wins, then HALTED next edge (the pipeline is empty after a flush).
- DRAIN:
  - stall = request pattern | 6'b000011, so fetch is frozen and bubbles enter ID.
  - dcnt increments only in cycles where stall==6'b000011 (no downstream request).
  - When dcnt==DRAIN_CYCLES-1 and it increments → HALTED.
  - Exception in DRAIN → flush, then HALTED next edge.
  - dbg_halt_req falling in DRAIN does not abort the drain.
- HALTED:
  - stall=6'b000011, dbg_halted=1.
  - dbg_resume=1 → RUN next edge.
  - Resume while dbg_halt_req is still 1 gives one RUN cycle, then DRAIN again (single-step).
  - An exception while HALTED is still flushed; the state stays HALTED.
- stall_cnt: +1 on each edge where the state is RUN, there is no exception, and the request pattern has bit0=1. It holds at 32'hFFFF_FFFF.

## Timing
- stall, flush, new_pc: combinational from the inputs and current state, zero latency.
- dbg_halted: decoded from registered state, so it changes one cycle after the transition edge.
- Halt latency with no requests: dbg_halt_req sampled at edge 0; DRAIN for edges 1..DRAIN_CYCLES; dbg_halted=1 after edge DRAIN_CYCLES+1 (5 cycles at the default).
- Every cycle with a downstream request in DRAIN adds exactly one cycle.
- Reset (rst=0, any time):
  - state=RUN, dcnt=0, stall_cnt=0, dbg_halted=0.
  - stall=0, flush=0, new_pc=0 are forced while rst=0, independent of inputs.
  - Release takes effect at the first rising edge with rst=1.

## Structure
- defines.v gains:
  - the stall patterns
  - the eret code 32'h0000_000e
  - the FSM state encodings (2 bits)
  - the `Stop/`NoStop usage for stall bits
- One sub-module, sat_counter (parameter WIDTH, inputs inc and clr, saturating), instantiated for stall_cnt.
- dcnt is sized $clog2(DRAIN_CYCLES+1) inline.

## Test plan
- stallreq_id=1 and stallreq_mem=1 together → stall=6'b011111, flush=0; stall_cnt +1 per cycle.
- excepttype_i=32'h0000_0008 with stallreq_ex=1 → flush=1, stall=0, new_pc=32'h0000_0020 in the same cycle; stall_cnt unchanged.
- excepttype_i=32'h0000_000e, cp0_epc_i=32'h8000_1234 → flush=1, new_pc=32'h8000_1234.
- dbg_halt_req=1 with no requests → stall=6'b000011 for 5 cycles, then dbg_halted=1. Repeat with stallreq_mem=1 for 2 cycles in DRAIN → dbg_halted 2 cycles later; stall=6'b011111 in those cycles.
- While HALTED, pulse dbg_resume with dbg_halt_req held → exactly one cycle with stall=0, then the drain restarts. Pulse rst low mid-DRAIN → outputs 0, state RUN, stall_cnt=0.
- Force stall_cnt to 32'hFFFF_FFFE, hold stallreq_if=1 for 3 cycles → reaches 32'hFFFF_FFFF and holds.
